// File: rtl/message_stitcher_if.sv
// Word-stream input and reassembled-message output bundle for message_stitcher.
// The master drives incoming words; the slave (the stitcher) drives the results.
interface message_stitcher_if #(
    parameter int WIDTH     = 32,
    parameter int MAXLENGTH = 4
);
    logic [WIDTH-1:0]           in_msg;
    logic                       in_msg_nd;
    logic [WIDTH-1:0]           out_header;
    logic [MAXLENGTH*WIDTH-1:0] out_payload;
    logic [9:0]                 out_length;
    logic                       out_nd;
    logic                       error;

    modport master (
        output in_msg, in_msg_nd,
        input  out_header, out_payload, out_length, out_nd, error
    );

    modport slave (
        input  in_msg, in_msg_nd,
        output out_header, out_payload, out_length, out_nd, error
    );
endinterface

// File: rtl/message_stitcher.sv
// Reassembles a header word plus up to MAXLENGTH payload words into one message,
// flagging orphan payload words and oversize headers as errors.
module message_stitcher #(
    parameter int WIDTH     = 32,
    parameter int MAXLENGTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    message_stitcher_if.slave bus
);
    localparam int PW = MAXLENGTH * WIDTH;

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

    state_t           state, state_nxt;
    logic [9:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] hdr, hdr_nxt;
    logic [PW-1:0]    pay, pay_nxt;
    logic [9:0]       len, len_nxt;

    logic [WIDTH-1:0] out_header, out_header_nxt;
    logic [PW-1:0]    out_payload, out_payload_nxt;
    logic [9:0]       out_length, out_length_nxt;
    logic             out_nd, out_nd_nxt;
    logic             error, error_nxt;

    logic             is_hdr;
    logic [9:0]       hdr_len;
    logic [PW-1:0]    shifted;

    assign is_hdr  = bus.in_msg[WIDTH-1];
    assign hdr_len = bus.in_msg[WIDTH-2 -: 10];
    // Newest word enters at the bottom, so the first word ends up highest.
    assign shifted = (pay << WIDTH) | PW'(bus.in_msg);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        hdr_nxt         = hdr;
        pay_nxt         = pay;
        len_nxt         = len;
        out_header_nxt  = out_header;
        out_payload_nxt = out_payload;
        out_length_nxt  = out_length;
        out_nd_nxt      = 1'b0;
        error_nxt       = 1'b0;

        if (bus.in_msg_nd) begin
            case (state)
                IDLE: begin
                    if (!is_hdr) begin
                        error_nxt = 1'b1;
                    end else if (hdr_len == 10'd0) begin
                        out_nd_nxt      = 1'b1;
                        out_header_nxt  = bus.in_msg;
                        out_payload_nxt = '0;
                        out_length_nxt  = 10'd0;
                    end else if (hdr_len > 10'(MAXLENGTH)) begin
                        error_nxt = 1'b1;
                        cnt_nxt   = hdr_len;
                        state_nxt = DISCARD;
                    end else begin
                        hdr_nxt   = bus.in_msg;
                        pay_nxt   = '0;
                        cnt_nxt   = hdr_len;
                        len_nxt   = hdr_len;
                        state_nxt = COLLECT;
                    end
                end
                COLLECT: begin
                    pay_nxt = shifted;
                    cnt_nxt = cnt - 10'd1;
                    if (cnt == 10'd1) begin
                        state_nxt       = IDLE;
                        out_nd_nxt      = 1'b1;
                        out_header_nxt  = hdr;
                        out_payload_nxt = shifted;
                        out_length_nxt  = len;
                    end
                end
                DISCARD: begin
                    cnt_nxt = cnt - 10'd1;
                    if (cnt == 10'd1) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hdr         <= '0;
            pay         <= '0;
            len         <= '0;
            out_header  <= '0;
            out_payload <= '0;
            out_length  <= '0;
            out_nd      <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hdr         <= hdr_nxt;
            pay         <= pay_nxt;
            len         <= len_nxt;
            out_header  <= out_header_nxt;
            out_payload <= out_payload_nxt;
            out_length  <= out_length_nxt;
            out_nd      <= out_nd_nxt;
            error       <= error_nxt;
        end
    end

    assign bus.out_header  = out_header;
    assign bus.out_payload = out_payload;
    assign bus.out_length  = out_length;
    assign bus.out_nd      = out_nd;
    assign bus.error       = error;
endmodule

// File: tb/tb_message_stitcher.sv
// Bench for message_stitcher: directed scenarios plus randomized message streams
// checked against a message-level reference model.
module tb_message_stitcher;
    localparam int W  = 32;
    localparam int M  = 4;
    localparam int PW = W * M;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    message_stitcher_if #(.WIDTH(W), .MAXLENGTH(M)) bus ();
    message_stitcher #(.WIDTH(W), .MAXLENGTH(M)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nd_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    logic [W-1:0]  exp_hdr = '0;
    logic [PW-1:0] exp_pay = '0;
    logic [9:0]    exp_len = '0;

    // Strobe tally, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.out_nd) nd_cnt <= nd_cnt + 1;
        if (bus.error) err_cnt <= err_cnt + 1;
        if (bus.out_nd && bus.error) both_cnt <= both_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [W-1:0] mkhdr(input int len);
        logic [W-1:0] h;
        h = $urandom;
        h[W-1] = 1'b1;
        h[W-2 -: 10] = len[9:0];
        return h;
    endfunction

    // Word i of L lands at word position L-1-i of the payload.
    function automatic logic [PW-1:0] model_pay(input logic [W-1:0] words[$]);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < words.size(); i++)
            p = p | (PW'(words[i]) << ((words.size() - 1 - i) * W));
        return p;
    endfunction

    task automatic put(input logic [W-1:0] w);
        bus.in_msg    = w;
        bus.in_msg_nd = 1'b1;
        @(posedge clk);
        #1;
        bus.in_msg_nd = 1'b0;
        bus.in_msg    = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_msg = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_msg_nd = 1'b0;
        bus.in_msg = $urandom;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_nd !== 1'b0) begin bad++; $display("FAIL reset_nd: got %0b want 0", bus.out_nd); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", bus.error); end
        total++; if (bus.out_header !== '0) begin bad++; $display("FAIL reset_hdr: got %0h want 0", bus.out_header); end
        total++; if (bus.out_payload !== '0) begin bad++; $display("FAIL reset_pay: got %0h want 0", bus.out_payload); end
        total++; if (bus.out_length !== 10'd0) begin bad++; $display("FAIL reset_len: got %0d want 0", bus.out_length); end
        rst_n = 1'b1;
        idle(2);
        total++; if (bus.out_nd !== 1'b0 || bus.error !== 1'b0) begin bad++; $display("FAIL reset_quiet: nd=%0b err=%0b want 0 0", bus.out_nd, bus.error); end
    endtask

    task automatic test_single;
        put(32'h8020_0000);
        total++; if (bus.out_nd !== 1'b0 || bus.error !== 1'b0) begin bad++; $display("FAIL single_hdr_quiet: nd=%0b err=%0b want 0 0", bus.out_nd, bus.error); end
        put(32'h0000_0007);
        total++; if (bus.out_nd !== 1'b1) begin bad++; $display("FAIL single_nd: got %0b want 1", bus.out_nd); end
        total++; if (bus.out_length !== 10'd1) begin bad++; $display("FAIL single_len: got %0d want 1", bus.out_length); end
        total++; if (bus.out_header !== 32'h8020_0000) begin bad++; $display("FAIL single_hdr: got %0h want 80200000", bus.out_header); end
        total++; if (bus.out_payload !== PW'(32'h7)) begin bad++; $display("FAIL single_pay: got %0h want 7", bus.out_payload); end
        exp_hdr = 32'h8020_0000; exp_pay = PW'(32'h7); exp_len = 10'd1;
        idle(1);
        total++; if (bus.out_nd !== 1'b0) begin bad++; $display("FAIL single_strobe: got %0b want 0", bus.out_nd); end
        total++; if (bus.out_header !== exp_hdr || bus.out_payload !== exp_pay || bus.out_length !== exp_len) begin
            bad++; $display("FAIL single_hold: hdr=%0h len=%0d want %0h %0d", bus.out_header, bus.out_length, exp_hdr, exp_len); end
    endtask

    task automatic test_gaps;
        int e0;
        e0 = err_cnt;
        put(32'h8040_0000);
        idle(3);
        put(32'hAAAA_AAAA);
        total++; if (bus.out_nd !== 1'b0) begin bad++; $display("FAIL gaps_mid_nd: got %0b want 0", bus.out_nd); end
        idle(2);
        put(32'h8000_0001);
        total++; if (bus.out_nd !== 1'b1) begin bad++; $display("FAIL gaps_nd: got %0b want 1", bus.out_nd); end
        total++; if (bus.out_payload !== PW'(64'hAAAA_AAAA_8000_0001)) begin bad++; $display("FAIL gaps_pay: got %0h want aaaaaaaa80000001", bus.out_payload); end
        total++; if (bus.out_length !== 10'd2) begin bad++; $display("FAIL gaps_len: got %0d want 2", bus.out_length); end
        exp_hdr = 32'h8040_0000; exp_pay = PW'(64'hAAAA_AAAA_8000_0001); exp_len = 10'd2;
        idle(1);
        total++; if (err_cnt != e0) begin bad++; $display("FAIL gaps_err: got %0d errors want 0", err_cnt - e0); end
    endtask

    task automatic test_zero;
        put(32'h8000_0000);
        total++; if (bus.out_nd !== 1'b1) begin bad++; $display("FAIL zero_nd: got %0b want 1", bus.out_nd); end
        total++; if (bus.out_length !== 10'd0) begin bad++; $display("FAIL zero_len: got %0d want 0", bus.out_length); end
        total++; if (bus.out_payload !== '0) begin bad++; $display("FAIL zero_pay: got %0h want 0", bus.out_payload); end
        total++; if (bus.out_header !== 32'h8000_0000) begin bad++; $display("FAIL zero_hdr: got %0h want 80000000", bus.out_header); end
        exp_hdr = 32'h8000_0000; exp_pay = '0; exp_len = 10'd0;
        idle(1);
    endtask

    task automatic test_oversize;
        int e0, n0;
        logic [W-1:0] w;
        logic [W-1:0] words[$];
        e0 = err_cnt; n0 = nd_cnt;
        put(32'h80A0_0000);
        total++; if (bus.error !== 1'b1 || bus.out_nd !== 1'b0) begin bad++; $display("FAIL over_err: err=%0b nd=%0b want 1 0", bus.error, bus.out_nd); end
        for (int i = 0; i < 5; i++) begin
            w = (i == 2) ? mkhdr(1) : $urandom;
            put(w);
            idle(i % 2);
        end
        idle(1);
        total++; if (err_cnt - e0 != 1 || nd_cnt != n0) begin bad++; $display("FAIL over_count: errors=%0d nd=%0d want 1 0", err_cnt - e0, nd_cnt - n0); end
        w = mkhdr(1);
        put(w);
        words.push_back($urandom);
        put(words[0]);
        total++; if (bus.out_nd !== 1'b1 || bus.out_length !== 10'd1 || bus.out_payload !== model_pay(words) || bus.out_header !== w) begin
            bad++; $display("FAIL over_next: nd=%0b len=%0d pay=%0h want 1 1 %0h", bus.out_nd, bus.out_length, bus.out_payload, model_pay(words)); end
        exp_hdr = w; exp_pay = model_pay(words); exp_len = 10'd1;
        idle(1);
    endtask

    task automatic test_orphan;
        logic [W-1:0] words[$];
        put(32'h0000_0003);
        total++; if (bus.error !== 1'b1 || bus.out_nd !== 1'b0) begin bad++; $display("FAIL orphan_err: err=%0b nd=%0b want 1 0", bus.error, bus.out_nd); end
        idle(1);
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL orphan_strobe: got %0b want 0", bus.error); end
        put(32'h8020_0000);
        words.push_back(32'h1234_5678);
        put(words[0]);
        total++; if (bus.out_nd !== 1'b1 || bus.out_payload !== model_pay(words)) begin bad++; $display("FAIL orphan_idle: nd=%0b pay=%0h want 1 12345678", bus.out_nd, bus.out_payload); end
        exp_hdr = 32'h8020_0000; exp_pay = model_pay(words); exp_len = 10'd1;
        idle(1);
    endtask

    task automatic test_back_to_back;
        int lens[3] = '{2, 1, 3};
        int n0;
        logic [W-1:0] h;
        logic [W-1:0] words[$];
        n0 = nd_cnt;
        for (int m = 0; m < 3; m++) begin
            h = mkhdr(lens[m]);
            put(h);
            if (m > 0) begin
                total++; if (bus.out_nd !== 1'b0) begin bad++; $display("FAIL b2b_strobe%0d: got %0b want 0", m, bus.out_nd); end
            end
            words.delete();
            for (int i = 0; i < lens[m]; i++) begin
                words.push_back($urandom);
                put(words[i]);
            end
            total++; if (bus.out_nd !== 1'b1 || bus.out_header !== h || bus.out_length !== 10'(lens[m]) || bus.out_payload !== model_pay(words)) begin
                bad++; $display("FAIL b2b_msg%0d: nd=%0b len=%0d pay=%0h want 1 %0d %0h", m, bus.out_nd, bus.out_length, bus.out_payload, lens[m], model_pay(words)); end
            exp_hdr = h; exp_pay = model_pay(words); exp_len = 10'(lens[m]);
        end
        idle(1);
        total++; if (nd_cnt - n0 != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", nd_cnt - n0); end
    endtask

    task automatic test_mid_reset;
        int e0, n0;
        logic [W-1:0] words[$];
        put(32'h8040_0000);
        put($urandom);
        e0 = err_cnt; n0 = nd_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++; if (bus.out_nd !== 1'b0 || bus.error !== 1'b0 || bus.out_header !== '0 || bus.out_payload !== '0 || bus.out_length !== 10'd0) begin
            bad++; $display("FAIL mreset_zero: nd=%0b err=%0b hdr=%0h len=%0d want all 0", bus.out_nd, bus.error, bus.out_header, bus.out_length); end
        exp_hdr = '0; exp_pay = '0; exp_len = '0;
        idle(2);
        total++; if (err_cnt != e0 || nd_cnt != n0) begin bad++; $display("FAIL mreset_quiet: errors=%0d nd=%0d want 0 0", err_cnt - e0, nd_cnt - n0); end
        put(32'h8020_0000);
        words.push_back($urandom);
        put(words[0]);
        total++; if (bus.out_nd !== 1'b1 || bus.out_length !== 10'd1 || bus.out_payload !== model_pay(words)) begin
            bad++; $display("FAIL mreset_fresh: nd=%0b len=%0d want 1 1", bus.out_nd, bus.out_length); end
        exp_hdr = 32'h8020_0000; exp_pay = model_pay(words); exp_len = 10'd1;
        idle(1);
    endtask

    task automatic test_random;
        int e0, n0, want_err, want_nd, kind, L;
        logic [W-1:0] h, w;
        logic [W-1:0] words[$];
        e0 = err_cnt; n0 = nd_cnt; want_err = 0; want_nd = 0;
        for (int m = 0; m < 40; m++) begin
            total++; if (bus.out_header !== exp_hdr || bus.out_payload !== exp_pay || bus.out_length !== exp_len) begin
                bad++; $display("FAIL rand_hold%0d: hdr=%0h len=%0d want %0h %0d", m, bus.out_header, bus.out_length, exp_hdr, exp_len); end
            kind = $urandom_range(0, 9);
            if (kind <= 6) begin
                L = $urandom_range(0, M);
                h = mkhdr(L);
                words.delete();
                put(h);
                if (L == 0) begin
                    total++; if (bus.out_nd !== 1'b1 || bus.out_header !== h || bus.out_length !== 10'd0 || bus.out_payload !== '0) begin
                        bad++; $display("FAIL rand_zero%0d: nd=%0b len=%0d pay=%0h want 1 0 0", m, bus.out_nd, bus.out_length, bus.out_payload); end
                end else begin
                    total++; if (bus.out_nd !== 1'b0 || bus.error !== 1'b0) begin bad++; $display("FAIL rand_hdr%0d: nd=%0b err=%0b want 0 0", m, bus.out_nd, bus.error); end
                    for (int i = 0; i < L; i++) begin
                        idle($urandom_range(0, 2));
                        w = $urandom;
                        words.push_back(w);
                        put(w);
                    end
                    total++; if (bus.out_nd !== 1'b1 || bus.error !== 1'b0 || bus.out_header !== h || bus.out_length !== 10'(L) || bus.out_payload !== model_pay(words)) begin
                        bad++; $display("FAIL rand_msg%0d: nd=%0b len=%0d pay=%0h want 1 %0d %0h", m, bus.out_nd, bus.out_length, bus.out_payload, L, model_pay(words)); end
                end
                exp_hdr = h; exp_pay = model_pay(words); exp_len = 10'(L);
                want_nd++;
            end else if (kind <= 8) begin
                L = $urandom_range(M + 1, 12);
                put(mkhdr(L));
                total++; if (bus.error !== 1'b1 || bus.out_nd !== 1'b0) begin bad++; $display("FAIL rand_over%0d: err=%0b nd=%0b want 1 0", m, bus.error, bus.out_nd); end
                for (int i = 0; i < L; i++) begin
                    idle($urandom_range(0, 1));
                    put($urandom);
                end
                want_err++;
            end else begin
                w = $urandom;
                w[W-1] = 1'b0;
                put(w);
                total++; if (bus.error !== 1'b1 || bus.out_nd !== 1'b0) begin bad++; $display("FAIL rand_orphan%0d: err=%0b nd=%0b want 1 0", m, bus.error, bus.out_nd); end
                want_err++;
            end
            idle($urandom_range(0, 1));
        end
        idle(2);
        total++; if (nd_cnt - n0 != want_nd) begin bad++; $display("FAIL rand_nd_count: got %0d want %0d", nd_cnt - n0, want_nd); end
        total++; if (err_cnt - e0 != want_err) begin bad++; $display("FAIL rand_err_count: got %0d want %0d", err_cnt - e0, want_err); end
        total++; if (both_cnt != 0) begin bad++; $display("FAIL nd_err_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        bus.in_msg    = '0;
        bus.in_msg_nd = 1'b0;
        test_reset();
        test_single();
        test_gaps();
        test_zero();
        test_oversize();
        test_orphan();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
